// File: rtl/xbus_pkg.sv
// Shared constants for the Xbus DMA initiator: widths, timeout and one-hot state encoding.
package xbus_pkg;

    localparam int XB_AW      = 22;
    localparam int XB_DW      = 32;
    localparam int XB_CW      = 10;
    localparam int XB_TIMEOUT = 63;
    localparam int XB_TW      = 6;
    localparam int XB_NST     = 8;

    // One-hot bit positions, matching busint's encoding style.
    localparam int I_IDLE  = 0;
    localparam int I_RBREQ = 1;
    localparam int I_RCYC  = 2;
    localparam int I_RREL  = 3;
    localparam int I_WBREQ = 4;
    localparam int I_WCYC  = 5;
    localparam int I_WREL  = 6;
    localparam int I_FIN   = 7;

    localparam logic [7:0] S_IDLE  = 8'b0000_0001;
    localparam logic [7:0] S_RBREQ = 8'b0000_0010;
    localparam logic [7:0] S_RCYC  = 8'b0000_0100;
    localparam logic [7:0] S_RREL  = 8'b0000_1000;
    localparam logic [7:0] S_WBREQ = 8'b0001_0000;
    localparam logic [7:0] S_WCYC  = 8'b0010_0000;
    localparam logic [7:0] S_WREL  = 8'b0100_0000;
    localparam logic [7:0] S_FIN   = 8'b1000_0000;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_BREQ = 2'd1,
        PH_CYC  = 2'd2,
        PH_REL  = 2'd3
    } phase_t;

endpackage

// File: rtl/xbus_mport.sv
// Single-access Xbus master handshake: request/grant, cycle/ack, release,
// plus decode check on the first cycle and the ack timeout.
module xbus_mport
    import xbus_pkg::*;
#(
    parameter int TIMEOUT = XB_TIMEOUT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  phase_t i_phase,
    input  logic   i_busgrantin,
    input  logic   i_ackin,
    input  logic   i_decodein,
    output logic   o_busreqout,
    output logic   o_reqout,
    output logic   o_granted,
    output logic   o_acked,
    output logic   o_released,
    output logic   o_err
);

    logic [XB_TW-1:0] r_tcnt;
    logic             r_in_cyc;
    logic             w_cyc;
    logic             w_first;
    logic             w_dec_err;
    logic             w_tmo;

    assign w_cyc     = (i_phase == PH_CYC);
    assign w_first   = w_cyc & ~r_in_cyc;
    assign w_dec_err = w_first & ~i_decodein;
    // Error on the last allowed reqout cycle so reqout is high exactly TIMEOUT cycles.
    assign w_tmo     = w_cyc & ~i_ackin & (r_tcnt == XB_TW'(TIMEOUT - 1));

    assign o_busreqout = (i_phase == PH_BREQ) | w_cyc;
    assign o_reqout    = w_cyc;
    assign o_granted   = (i_phase == PH_BREQ) & i_busgrantin;
    assign o_acked     = w_cyc & i_ackin & ~w_dec_err;
    assign o_err       = w_dec_err | w_tmo;
    assign o_released  = (i_phase == PH_REL) & ~i_ackin & ~i_busgrantin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cyc <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_in_cyc <= w_cyc;
            if (!w_cyc)
                r_tcnt <= '0;
            else if (r_tcnt != XB_TW'(TIMEOUT))
                r_tcnt <= r_tcnt + 1'b1;
        end
    end

endmodule

// File: rtl/xbus_dma.sv
// Xbus block-copy DMA initiator: copies a run of words src->dst, releasing
// the bus between every access, and raises an interrupt when finished.
//
// state | meaning
// IDLE  | waiting for cmd_start
// RBREQ | requesting the bus for the source read
// RCYC  | read cycle, waiting for ack
// RREL  | read tenure released, waiting for ack/grant to fall
// WBREQ | requesting the bus for the destination write
// WCYC  | write cycle, waiting for ack
// WREL  | write tenure released, advance pointers/count
// FIN   | completion (ok or error)
module xbus_dma
    import xbus_pkg::*;
#(
    parameter int AW      = XB_AW,
    parameter int CW      = XB_CW,
    parameter int TIMEOUT = XB_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_start,
    input  logic [AW-1:0]    i_cmd_src,
    input  logic [AW-1:0]    i_cmd_dst,
    input  logic [CW-1:0]    i_cmd_count,
    output logic             o_cmd_busy,
    output logic             o_cmd_done,
    output logic             o_cmd_err,
    output logic             o_interrupt,
    input  logic             i_irq_clear,
    output logic             o_busreqout,
    input  logic             i_busgrantin,
    output logic [AW-1:0]    o_addrout,
    output logic [XB_DW-1:0] o_dataout,
    input  logic [XB_DW-1:0] i_datain,
    output logic             o_reqout,
    output logic             o_writeout,
    input  logic             i_ackin,
    input  logic             i_decodein
);

    logic [XB_NST-1:0] r_state;
    logic [XB_NST-1:0] w_state_nxt;
    logic [AW-1:0]     r_src;
    logic [AW-1:0]     r_dst;
    logic [CW-1:0]     r_count;
    logic [XB_DW-1:0]  r_hold;
    logic              r_done;
    logic              r_err;
    logic              r_irq;
    phase_t            w_phase;
    logic              w_granted;
    logic              w_acked;
    logic              w_released;
    logic              w_err;
    logic              w_accept;

    assign w_accept = r_state[I_IDLE] & i_cmd_start;

    always_comb begin
        w_phase = PH_NONE;
        if (r_state[I_RBREQ] | r_state[I_WBREQ])
            w_phase = PH_BREQ;
        else if (r_state[I_RCYC] | r_state[I_WCYC])
            w_phase = PH_CYC;
        else if (r_state[I_RREL] | r_state[I_WREL])
            w_phase = PH_REL;
    end

    xbus_mport #(.TIMEOUT(TIMEOUT)) u_mport (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_phase      (w_phase),
        .i_busgrantin (i_busgrantin),
        .i_ackin      (i_ackin),
        .i_decodein   (i_decodein),
        .o_busreqout  (o_busreqout),
        .o_reqout     (o_reqout),
        .o_granted    (w_granted),
        .o_acked      (w_acked),
        .o_released   (w_released),
        .o_err        (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_cmd_start) w_state_nxt = (i_cmd_count == '0) ? S_FIN : S_RBREQ;
            S_RBREQ: if (w_granted) w_state_nxt = S_RCYC;
            S_RCYC: begin
                if (w_err)
                    w_state_nxt = S_FIN;
                else if (w_acked)
                    w_state_nxt = S_RREL;
            end
            S_RREL:  if (w_released) w_state_nxt = S_WBREQ;
            S_WBREQ: if (w_granted) w_state_nxt = S_WCYC;
            S_WCYC: begin
                if (w_err)
                    w_state_nxt = S_FIN;
                else if (w_acked)
                    w_state_nxt = S_WREL;
            end
            S_WREL:  if (w_released) w_state_nxt = (r_count == CW'(1)) ? S_FIN : S_RBREQ;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_count <= '0;
            r_hold  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= r_state[I_FIN];
            if (w_accept) begin
                r_src   <= i_cmd_src;
                r_dst   <= i_cmd_dst;
                r_count <= i_cmd_count;
                r_err   <= 1'b0;
            end else if (r_state[I_WREL] & w_released) begin
                r_src   <= r_src + 1'b1;
                r_dst   <= r_dst + 1'b1;
                r_count <= r_count - 1'b1;
            end
            if (r_state[I_RCYC] & w_acked)
                r_hold <= i_datain;
            if (w_err)
                r_err <= 1'b1;
            // Completion beats a same-cycle irq_clear.
            if (r_state[I_FIN])
                r_irq <= 1'b1;
            else if (i_irq_clear | w_accept)
                r_irq <= 1'b0;
        end
    end

    assign o_cmd_busy  = ~r_state[I_IDLE] & ~r_state[I_FIN];
    assign o_cmd_done  = r_done;
    assign o_cmd_err   = r_err;
    assign o_interrupt = r_irq;
    assign o_writeout  = r_state[I_WCYC];
    assign o_dataout   = r_hold;
    assign o_addrout   = r_state[I_RCYC] ? r_src :
                         r_state[I_WCYC] ? r_dst : '0;

endmodule
